int_sop_n_dspchain_acc: RTL and testbench
=========================================

# int_sop_n_dspchain_acc

Pipelined unsigned sum-of-N-products stage for DSP cascade chains: computes Σ a[i]·b[i] + chainin over N_TERMS lanes, with an optional accumulate mode that sums ACC_LEN consecutive valid beats before emitting one result. It generalises the fixed two-term chain stage with parametrised term count and widths, valid tracking, and accumulation. It sits in the soft-DSP chain fabric: chainout feeds the next stage's chainin.

## Interface
- N_TERMS, 4, number of product lanes (≥1)
- AW, 18, width of each a operand
- BW, 19, width of each b operand
- CW, 37, width of chainin, result, chainout and accumulator
- ACC_LEN, 4, beats per accumulation window (≥1)
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high
- in_valid  in  1  beat qualifier for a, b, chainin, mode
- mode  in  1  0 = pass (one result per beat), 1 = accumulate
- a  in  N_TERMS*AW  packed lanes, lane i = a[i*AW +: AW]
- b  in  N_TERMS*BW  packed lanes, lane i = b[i*BW +: BW]
- chainin  in  CW  cascade input from previous stage
- out_valid  out  1  one-cycle pulse, result is new
- result  out  CW  registered result
- chainout  out  CW  equals result (same register, no extra delay)

## Operation
- Stage 1: on in_valid, register a, b, chainin, mode; v1 <= in_valid. Data registers hold when in_valid is low.
- Stage 2: register the N_TERMS products (AW+BW bits each, unsigned) and chainin/mode; v2 <= v1.
- Stage 3: s = Σ products + chainin, truncated to CW (mod 2^CW).
- Pass beat (mode=0): result <= s, out_valid <= 1. Accumulator and counter are untouched.
- Accumulate beat (mode=1), counter cnt in 0..ACC_LEN-1:
  - acc_next = s when cnt==0, otherwise acc + s − chainin. chainin is therefore counted only on the first beat of each window.
  - If cnt==ACC_LEN-1: result <= acc_next, out_valid <= 1, acc <= 0, cnt <= 0.
  - Otherwise: acc <= acc_next, cnt <= cnt+1, out_valid <= 0.
- mode travels with its beat. Pass beats interleaved inside an open window emit normally and leave the window intact.
- Bubbles (in_valid low) do not advance cnt.
- ACC_LEN=1 makes accumulate behave exactly like pass.
- No backpressure: the pipeline always advances.
- Each beat produces at most one output, so outputs never conflict.
- When out_valid is low, result and chainout hold their last value.

## Timing
- Latency 3: a beat sampled at edge E0 produces result/out_valid after edge E2, visible in the cycle after E2.
- Throughput is one beat per cycle. Back-to-back beats give back-to-back out_valid pulses, and input gaps are preserved at the output.
- In accumulate mode, out_valid appears 3 cycles after the ACC_LEN-th accumulate beat.
- Reset values: out_valid=0, result=0, chainout=0; all stage registers, v1, v2, acc and cnt are 0.
- Reset mid-operation: in-flight beats and any partial window are discarded. No out_valid in the cycle after reset deasserts. The next accumulate beat starts a fresh window.

## Configuration
- SOP_SATURATE_EN defined:
  - Stage-3 sum and accumulator saturate to 2^CW−1 instead of wrapping.
  - Saturation is sticky within a window until emit or reset.
- Undefined: all arithmetic wraps modulo 2^CW.

## Test plan
Default parameters unless stated.
- Pass: a={1,2,3,4}, b={5,6,7,8}, chainin=10, mode=0, one beat → result=80, out_valid pulse 3 cycles later, chainout=80.
- Throughput: 3 consecutive pass beats, 2-cycle gap, 1 beat → out_valid pattern 1,1,1,0,0,1 starting at latency 3.
- Accumulate: 4 mode=1 beats with lanes as in the pass test and chainin=10 each, 1-cycle bubbles between them → single out_valid, result=290.
- Overflow: all lanes a=2^18−1, b=2^19−1, chainin=0, pass → result=137435807748 without the macro; 137438953471 with SOP_SATURATE_EN.
- Reset: 2 accumulate beats, then reset for 1 cycle, then 4 accumulate beats as in the accumulate test → exactly one out_valid, result=290.
- Interleave: accumulate, accumulate, pass (result 80), accumulate, accumulate → pass output 80 appears in order, window result=290.

Source files
------------

// File: rtl/int_sop_n_dspchain_acc.sv
// int_sop_n_dspchain_acc
//   Pipelined unsigned sum-of-N-products stage for soft-DSP cascade chains.
//   Computes sum(a[i]*b[i]) + chainin over N_TERMS lanes. In accumulate mode,
//   ACC_LEN consecutive valid accumulate beats are summed before one result is
//   emitted. In that case chainin is counted only on the first beat of each window.
//   Latency is 3 cycles and throughput is one beat per cycle.
//
// Ports
//   clk        clock, all logic on posedge
//   reset      synchronous, active-high
//   in_valid   beat qualifier for a, b, chainin, mode
//   mode       0 = pass (one result per beat), 1 = accumulate
//   a          N_TERMS packed AW-bit lanes, lane i = a[i*AW +: AW]
//   b          N_TERMS packed BW-bit lanes, lane i = b[i*BW +: BW]
//   chainin    cascade input from the previous stage
//   out_valid  one-cycle pulse when result is new
//   result     registered result (holds when out_valid is low)
//   chainout   same register as result, feeds the next stage's chainin
//
// Build option
//   SOP_SATURATE_EN  when defined, the stage-3 sum and the accumulator saturate
//                    to 2^CW-1, sticky within a window. Otherwise all arithmetic
//                    wraps modulo 2^CW.
module int_sop_n_dspchain_acc #(
  parameter int N_TERMS = 4,
  parameter int AW      = 18,
  parameter int BW      = 19,
  parameter int CW      = 37,
  parameter int ACC_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  mode,
  input  logic [N_TERMS*AW-1:0] a,
  input  logic [N_TERMS*BW-1:0] b,
  input  logic [CW-1:0]         chainin,
  output logic                  out_valid,
  output logic [CW-1:0]         result,
  output logic [CW-1:0]         chainout
);

  localparam int PW   = AW + BW;
  localparam int CNTW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ACC_LEN - 1);

  // Stage 1: input capture
  logic [N_TERMS*AW-1:0] a1_q, a1_d;
  logic [N_TERMS*BW-1:0] b1_q, b1_d;
  logic [CW-1:0]         ci1_q, ci1_d;
  logic                  m1_q, m1_d;
  logic                  v1_q, v1_d;

  // Stage 2: products
  logic [PW-1:0]         prod_q [N_TERMS];
  logic [PW-1:0]         prod_d [N_TERMS];
  logic [CW-1:0]         ci2_q, ci2_d;
  logic                  m2_q, m2_d;
  logic                  v2_q, v2_d;

  // Stage 3: sum, accumulator, output
  logic [CW-1:0]         s;
  logic [CW-1:0]         acc_nx;
  logic [CW-1:0]         acc_q, acc_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]         result_q, result_d;
  logic                  out_valid_q, out_valid_d;

  // Stage 1
  always_comb begin
    a1_d  = in_valid ? a        : a1_q;
    b1_d  = in_valid ? b        : b1_q;
    ci1_d = in_valid ? chainin  : ci1_q;
    m1_d  = in_valid ? mode     : m1_q;
    v1_d  = in_valid;
  end

  // Stage 2
  always_comb begin
    for (int unsigned i = 0; i < N_TERMS; i++) begin
      prod_d[i] = v1_q ? (PW'(a1_q[i*AW +: AW]) * PW'(b1_q[i*BW +: BW])) : prod_q[i];
    end
    ci2_d = v1_q ? ci1_q : ci2_q;
    m2_d  = v1_q ? m1_q  : m2_q;
    v2_d  = v1_q;
  end

`ifdef SOP_SATURATE_EN
  localparam int MW = (PW > CW) ? PW : CW;
  localparam int SW = MW + $clog2(N_TERMS + 2) + 1;

  logic [SW-1:0] psum_w, s_w, acc_w;
  logic          s_ovf;
  logic          acc_nx_sat;
  logic          sat_q, sat_d;

  // The sums are computed wide enough that any carry past CW is visible.
  // The accumulator adds only the product sum, which is the same as
  // acc + s - chainin. A window that has overflowed stays pinned at
  // full scale through sat_q.
  always_comb begin
    psum_w = '0;
    for (int unsigned i = 0; i < N_TERMS; i++) begin
      psum_w = psum_w + SW'(prod_q[i]);
    end
    s_w   = psum_w + SW'(ci2_q);
    acc_w = SW'(acc_q) + psum_w;
    s_ovf = |s_w[SW-1:CW];
    s     = s_ovf ? '1 : s_w[CW-1:0];
    if (cnt_q == '0) begin
      acc_nx_sat = s_ovf;
      acc_nx     = s;
    end else begin
      acc_nx_sat = sat_q | (|acc_w[SW-1:CW]);
      acc_nx     = acc_nx_sat ? '1 : acc_w[CW-1:0];
    end
  end
`else
  logic [CW-1:0] psum_c;

  // With wrapping arithmetic, acc + s - chainin reduces to acc + sum of products.
  always_comb begin
    psum_c = '0;
    for (int unsigned i = 0; i < N_TERMS; i++) begin
      psum_c = psum_c + CW'(prod_q[i]);
    end
    s      = psum_c + ci2_q;
    acc_nx = (cnt_q == '0) ? s : (acc_q + psum_c);
  end
`endif

  // Stage 3 control: pass beats leave the window untouched
  always_comb begin
    out_valid_d = 1'b0;
    result_d    = result_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
`ifdef SOP_SATURATE_EN
    sat_d       = sat_q;
`endif
    if (v2_q) begin
      if (!m2_q) begin
        result_d    = s;
        out_valid_d = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        result_d    = acc_nx;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
`ifdef SOP_SATURATE_EN
        sat_d       = 1'b0;
`endif
      end else begin
        acc_d = acc_nx;
        cnt_d = cnt_q + CNTW'(1);
`ifdef SOP_SATURATE_EN
        sat_d = acc_nx_sat;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a1_q        <= '0;
      b1_q        <= '0;
      ci1_q       <= '0;
      m1_q        <= 1'b0;
      v1_q        <= 1'b0;
      for (int unsigned i = 0; i < N_TERMS; i++) begin
        prod_q[i] <= '0;
      end
      ci2_q       <= '0;
      m2_q        <= 1'b0;
      v2_q        <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
`ifdef SOP_SATURATE_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      ci1_q       <= ci1_d;
      m1_q        <= m1_d;
      v1_q        <= v1_d;
      for (int unsigned i = 0; i < N_TERMS; i++) begin
        prod_q[i] <= prod_d[i];
      end
      ci2_q       <= ci2_d;
      m2_q        <= m2_d;
      v2_q        <= v2_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
`ifdef SOP_SATURATE_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign chainout  = result_q;

endmodule

// File: tb/tb_int_sop_n_dspchain_acc.sv
module tb_int_sop_n_dspchain_acc;

  localparam int N   = 4;
  localparam int AW  = 18;
  localparam int BW  = 19;
  localparam int CW  = 37;
  localparam int ACC = 4;
  localparam logic [63:0] CMAX = (64'd1 << CW) - 64'd1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            mode = 1'b0;
  logic [N*AW-1:0] a = '0;
  logic [N*BW-1:0] b = '0;
  logic [CW-1:0]   chainin = '0;
  logic            out_valid;
  logic [CW-1:0]   result;
  logic [CW-1:0]   chainout;

  int total = 0;
  int bad   = 0;

  logic [CW-1:0] sbq [$];
  logic [2:0]    exp_v = 3'b0;
  logic          emit_now = 1'b0;
  logic          mon_en = 1'b0;

  // Reference window state: exact unbounded total, reduced at emit time
  logic [63:0] m_tot = '0;
  int          m_cnt = 0;

  int_sop_n_dspchain_acc #(
    .N_TERMS(N), .AW(AW), .BW(BW), .CW(CW), .ACC_LEN(ACC)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode),
    .a(a), .b(b), .chainin(chainin),
    .out_valid(out_valid), .result(result), .chainout(chainout)
  );

  always #5 clk = ~clk;

  // Expected out_valid: each beat is tagged when it enters, then shifted 3 edges
  always @(posedge clk) begin
    if (reset) exp_v <= 3'b0;
    else       exp_v <= {exp_v[1:0], emit_now};
  end

  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      assert (out_valid === exp_v[2]) else begin
        bad++;
        $error("FAIL out_valid: got %b want %b", out_valid, exp_v[2]);
      end
      if (out_valid) begin
        total++;
        assert (sbq.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_out: got result %0d want no output", result);
        end
        if (sbq.size() != 0) begin
          logic [CW-1:0] e;
          e = sbq.pop_front();
          total++;
          assert (result === e) else begin
            bad++;
            $error("FAIL result: got %0d want %0d", result, e);
          end
          total++;
          assert (chainout === e) else begin
            bad++;
            $error("FAIL chainout: got %0d want %0d", chainout, e);
          end
        end
      end
    end
  end

  function automatic logic [63:0] prods(input logic [N*AW-1:0] av, input logic [N*BW-1:0] bv);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p = p + 64'(av[i*AW +: AW]) * 64'(bv[i*BW +: BW]);
    return p;
  endfunction

  function automatic logic [CW-1:0] fin(input logic [63:0] x);
`ifdef SOP_SATURATE_EN
    return (x > CMAX) ? CW'(CMAX) : CW'(x);
`else
    return CW'(x & CMAX);
`endif
  endfunction

  function automatic logic [N*AW-1:0] pa(input int x0, input int x1, input int x2, input int x3);
    return {AW'(x3), AW'(x2), AW'(x1), AW'(x0)};
  endfunction

  function automatic logic [N*BW-1:0] pb(input int x0, input int x1, input int x2, input int x3);
    return {BW'(x3), BW'(x2), BW'(x1), BW'(x0)};
  endfunction

  task automatic beat(input logic m, input logic [N*AW-1:0] av,
                      input logic [N*BW-1:0] bv, input logic [CW-1:0] ci);
    logic [63:0] p;
    logic        em;
    p  = prods(av, bv);
    em = 1'b0;
    if (!m) begin
      sbq.push_back(fin(p + 64'(ci)));
      em = 1'b1;
    end else begin
      m_tot = m_tot + p + ((m_cnt == 0) ? 64'(ci) : 64'd0);
      m_cnt++;
      if (m_cnt == ACC) begin
        sbq.push_back(fin(m_tot));
        m_tot = '0;
        m_cnt = 0;
        em    = 1'b1;
      end
    end
    in_valid = 1'b1; mode = m; a = av; b = bv; chainin = ci; emit_now = em;
    @(posedge clk); #1;
    in_valid = 1'b0; emit_now = 1'b0;
    a = {N*AW{1'b1}}; b = {N*BW{1'b1}}; chainin = '1; mode = ~m;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [N*AW-1:0] av1, avmax;
    logic [N*BW-1:0] bv1, bvmax;
    av1   = pa(1, 2, 3, 4);
    bv1   = pb(5, 6, 7, 8);
    avmax = {N*AW{1'b1}};
    bvmax = {N*BW{1'b1}};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    assert (out_valid === 1'b0) else begin bad++; $error("FAIL rst_valid: got %b want 0", out_valid); end
    total++;
    assert (result === '0) else begin bad++; $error("FAIL rst_result: got %0d want 0", result); end
    total++;
    assert (chainout === '0) else begin bad++; $error("FAIL rst_chainout: got %0d want 0", chainout); end
    reset = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Single pass beat: 80
    beat(1'b0, av1, bv1, 37'd10);
    idle(5);

    // Throughput: 3 beats, 2-cycle gap, 1 beat
    beat(1'b0, av1, bv1, 37'd1);
    beat(1'b0, pa(2, 0, 0, 0), pb(3, 0, 0, 0), 37'd0);
    beat(1'b0, av1, bv1, 37'd100);
    idle(2);
    beat(1'b0, pa(7, 7, 7, 7), pb(1, 2, 3, 4), 37'd5);
    idle(5);

    // Accumulate with bubbles: 290
    for (int k = 0; k < ACC; k++) begin
      beat(1'b1, av1, bv1, 37'd10);
      idle(1);
    end
    idle(5);

    // Overflow / saturation
    beat(1'b0, avmax, bvmax, 37'd0);
    idle(5);

    // Reset drops a partial window
    beat(1'b1, av1, bv1, 37'd10);
    beat(1'b1, av1, bv1, 37'd10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_tot = '0;
    m_cnt = 0;
    for (int k = 0; k < ACC; k++) beat(1'b1, av1, bv1, 37'd10);
    idle(5);

    // Pass interleaved in an open window
    beat(1'b1, av1, bv1, 37'd10);
    beat(1'b1, av1, bv1, 37'd10);
    beat(1'b0, av1, bv1, 37'd10);
    beat(1'b1, av1, bv1, 37'd10);
    beat(1'b1, av1, bv1, 37'd10);
    idle(5);

    // Accumulated overflow across a window
    for (int k = 0; k < ACC; k++) beat(1'b1, avmax, bvmax, CW'(CMAX));
    idle(5);

    // Random mix of modes, operands and gaps
    for (int k = 0; k < 24; k++) begin
      beat(1'($urandom_range(0, 1)),
           {AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom)},
           {BW'($urandom), BW'($urandom), BW'($urandom), BW'($urandom)},
           {5'($urandom), 32'($urandom)});
      idle($urandom_range(0, 2));
    end
    // Close any open window so every queued result drains
    while (m_cnt != 0) beat(1'b1, pa(1, 1, 1, 1), pb(1, 1, 1, 1), 37'd3);
    idle(6);

    total++;
    assert (sbq.size() == 0) else begin
      bad++;
      $error("FAIL drain: got %0d pending want 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
